// File: rtl/sum_burst_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_burst_accumulator_pkg
// Brief    : Shared FSM state encoding and parameter-legality helper for the
//            sum burst accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package sum_burst_accumulator_pkg;

  // FSM state encoding shared with anything that observes the accumulator state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // True when the parameter set describes a buildable accumulator
  function automatic bit params_ok(input int width, input int acc_width,
                                   input int burst, input int cnt_w);
    return (width >= 1) && (acc_width >= width + 1) && (burst >= 1) &&
           (cnt_w >= $clog2(burst + 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sum_burst_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : sum_burst_accumulator_if
// Brief    : Input sum stream, output total stream and status of the
//            sum burst accumulator. slave = accumulator side,
//            master = producer/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface sum_burst_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12,
  parameter int CNT_W     = 3
);
  logic [WIDTH:0]       in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;
  logic [CNT_W-1:0]     count;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, overflow, count
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, overflow, count
  );
endinterface
`default_nettype wire

// File: rtl/sum_burst_accumulator_acc_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module   : acc_prefix_adder
// Brief    : Combinational parallel-prefix (Kogge-Stone style) adder with
//            carry-out, same generate/propagate scheme as the fast adder.
// Revision : 1.0 - initial release
// ============================================================================
module acc_prefix_adder #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g_nxt;
  logic [WIDTH-1:0] w_p_nxt;
  logic [WIDTH-1:0] w_carry;

  // Prefix tree: after the last level w_g[i] is the group generate of bits [i:0]
  always_comb begin
    w_g     = a_i & b_i;
    w_p     = a_i ^ b_i;
    w_g_nxt = w_g;
    w_p_nxt = w_p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      w_g_nxt = w_g;
      w_p_nxt = w_p;
      for (int i = d; i < WIDTH; i++) begin
        w_g_nxt[i] = w_g[i] | (w_p[i] & w_g[i-d]);
        w_p_nxt[i] = w_p[i] & w_p[i-d];
      end
      w_g = w_g_nxt;
      w_p = w_p_nxt;
    end
    // Carry into bit i is the group generate of everything below it
    w_carry    = '0;
    for (int i = 1; i < WIDTH; i++) begin
      w_carry[i] = w_g[i-1];
    end
    sum_o  = a_i ^ b_i ^ w_carry;
    cout_o = w_g[WIDTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/sum_burst_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_burst_accumulator
// Brief    : Accumulates BURST consecutive fast-adder sums into one total,
//            presented on a valid/ready port with a sticky overflow flag.
//            Macro SUM_ACC_SATURATE_EN: clamp the total to all-ones on
//            overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
import sum_burst_accumulator_pkg::*;

module sum_burst_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12,
  parameter int BURST     = 4,
  parameter int CNT_W     = $clog2(BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  sum_burst_accumulator_if.slave        bus
);

  generate
    if (!params_ok(WIDTH, ACC_WIDTH, BURST, CNT_W)) begin : g_param_check
      $error("sum_burst_accumulator: illegal WIDTH/ACC_WIDTH/BURST/CNT_W");
    end
  endgenerate

  state_t               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] out_data_q;
  logic                 out_valid_q;
  logic                 ovf_q;
  logic [CNT_W-1:0]     count_q;

  logic [ACC_WIDTH-1:0] sum_w;
  logic                 cout_w;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 ovf_d;
  logic                 in_ready_w;
  logic                 accept_w;
  logic                 xfer_w;
  logic                 last_beat_w;

  // Ready depends only on state, so no combinational path from valid/ready inputs
  assign in_ready_w  = (state_q != HOLD);
  assign accept_w    = bus.in_valid & in_ready_w;
  assign xfer_w      = out_valid_q & bus.out_ready;
  assign last_beat_w = (count_q == CNT_W'(BURST - 1));

  acc_prefix_adder #(
    .WIDTH (ACC_WIDTH)
  ) u_adder (
    .a_i    (acc_q),
    .b_i    (ACC_WIDTH'(bus.in_data)),
    .sum_o  (sum_w),
    .cout_o (cout_w)
  );

  // Overflow is sticky across the burst; a clamped acc keeps re-overflowing or stays all-ones
  assign ovf_d = ovf_q | cout_w;
`ifdef SUM_ACC_SATURATE_EN
  assign acc_d = ovf_d ? {ACC_WIDTH{1'b1}} : sum_w;
`else
  assign acc_d = sum_w;
`endif

  // Burst FSM with accumulator, beat counter and registered output port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept_w) begin
            acc_q   <= acc_d;
            count_q <= count_q + CNT_W'(1);
            ovf_q   <= ovf_d;
            if (last_beat_w) begin
              out_data_q  <= acc_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (xfer_w) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = ovf_q;
  assign bus.count     = count_q;

endmodule
`default_nettype wire
